// File: rtl/grant_response_router.sv
// Return path for the 2-requester round-robin arbiter: it queues each granted ID in an
// in-order tag FIFO and steers every shared-resource response back to the matching requester.
module grant_response_router #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 grants,
   input  logic                       rsp_valid,
   input  logic [DATA_W-1:0]          rsp_data,
   output logic [1:0]                 out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [2:0]                 err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] tags;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             grant_one;
   logic             grant_bad;
   logic             push;
   logic             pop;
   logic             head;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // A pop in the same cycle frees a slot, so a grant on a full FIFO still lands.
   always_comb begin
      grant_one = (grants == 2'b01) || (grants == 2'b10);
      grant_bad = (grants == 2'b11);
      pop       = rsp_valid && !empty;
      push      = grant_one && (!full || pop);
      head      = tags[rd_ptr];
   end

   // Tag storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) tags[wr_ptr] <= grants[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         out_valid <= '0;
         out_data  <= '0;
         err       <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         out_valid <= pop ? (head ? 2'b10 : 2'b01) : 2'b00;
         if (pop) out_data <= rsp_data;
         if (grant_bad)                err[0] <= 1'b1;
         if (grant_one && full && !pop) err[1] <= 1'b1;
         if (rsp_valid && empty)       err[2] <= 1'b1;
      end
   end

endmodule

// File: doc/grant_response_router.md
# grant_response_router

Return-path companion to the 2-requester round-robin arbiter. Each cycle it records which requester the arbiter granted, storing the ID in an in-order tag FIFO. It then steers each response from the shared resource back to the requester that issued the matching grant. It sits between the shared resource's response port and the two requesters. Its `full` output is fed back to mask arbiter requests.

## Interface

Parameters:

- DATA_W, 8, response payload width
- DEPTH, 4, tag FIFO entries; power of two, ≥ 2

Ports:

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- grants  input  2  arbiter grant vector; 01 or 10 = one grant; 00 = none; 11 = illegal
- rsp_valid  input  1  shared resource returns one response this cycle
- rsp_data  input  DATA_W  response payload
- out_valid  output  2  registered one-hot: bit i = response delivered to requester i
- out_data  output  DATA_W  registered payload, shared by both requesters
- full  output  1  tag FIFO holds DEPTH entries
- empty  output  1  tag FIFO holds 0 entries
- count  output  $clog2(DEPTH+1)  current tag occupancy
- err  output  3  sticky error flags: [0] illegal grant 11, [1] overflow, [2] underflow

## Operation

- Tag FIFO:
  - DEPTH entries, 1 bit each (0 = requester 0, 1 = requester 1).
  - Write and read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count tracks occupancy explicitly; full = (count == DEPTH); empty = (count == 0).
- Push:
  - Occurs when grants is 01 or 10 and (not full, or a pop happens in the same cycle).
  - Tag written = grants[1].
- Pop:
  - Occurs when rsp_valid and not empty.
  - The head tag selects the destination: out_valid[tag] <= 1 and out_data <= rsp_data next cycle.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, a same-cycle pop frees the slot for the push.
- No bypass: a grant and a response in the same cycle with the FIFO empty is an underflow. The response must arrive at least 1 cycle after its grant.
- Errors (no state change for the offending event):
  - grants == 11: no push; err[0] set.
  - Grant while full with no same-cycle pop: tag dropped; err[1] set.
  - rsp_valid while empty: response dropped; out_valid stays 00; err[2] set.
- err bits are sticky; only rst clears them.
- out_data holds its last value when out_valid == 00; it updates only on a pop.
- The block has no backpressure toward the shared resource. The requesters must accept out_valid unconditionally.

## Timing

- Reset (asynchronous, takes effect immediately):
  - out_valid = 00, out_data = 0, pointers = 0, count = 0, empty = 1, full = 0, err = 000.
  - Tag storage contents are don't-care.
- Latency:
  - rsp_valid at edge N produces out_valid/out_data valid in cycle N+1, for exactly 1 cycle per response.
  - A grant at edge N is visible in count/full/empty after edge N; full, empty and count are registered or derived from registered count.
- Throughput: 1 push and 1 pop per cycle sustained.
- Ordering: responses are routed strictly in grant order (FIFO).
- Reset mid-operation: all pending tags are discarded. The next response after reset with no new grant is an underflow.

## Test plan

- Reset, then grants 01,10,10 (cycles 1–3), then rsp_valid with data A1,B2,C3 (cycles 5–7):
  - count reaches 3.
  - out_valid = 01/A1, 10/B2, 10/C3 in cycles 6–8.
  - Ends empty = 1, err = 000.
- DEPTH=4: four grants alternating 01/10 → full = 1. A fifth grant 01 with no response → err[1] = 1, count stays 4, and the four responses return tags 0,1,0,1.
- Full FIFO, then grant 10 and rsp_valid in the same cycle:
  - Head routed correctly; count stays 4.
  - New tag 1 is delivered last; err[1] stays 0.
- grants = 11 for one cycle → err[0] = 1, count unchanged. rsp_valid on an empty FIFO → err[2] = 1, out_valid = 00.
- Wrap-around: 10 push/pop pairs with random tags, occupancy ≤ 3 → every delivery matches its grant; pointers wrap with no error.
- Assert rst asynchronously, mid-cycle, with 2 tags pending → outputs clear immediately. A post-reset response sets err[2]; a new grant 10 then response D4 → out_valid = 10, out_data = D4.
